ring_buffer_param: RTL and testbench

RING_BUFFER_PARAM -- requirements
Module: ring_buffer_param

---
 rtl/ring_buffer_param.sv | 113 +++++++++++
 tb/tb_ring_buffer_param.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ring_buffer_param.sv
// Set-wide ring buffer: one-cycle registered read, write-while-full allowed only with a read, no empty bypass.
// Optional sticky overflow/underflow outputs when RING_BUFFER_ERR_FLAG_EN is defined.
module ring_buffer_param #(
   parameter int DATA_OF_SET = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 4,
   parameter int AF_LEVEL    = 3,
   parameter int AE_LEVEL    = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  wen,
   input  logic                                  ren,
   input  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] din,
   output logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] dout,
   output logic                                  full_flag,
   output logic                                  empty_flag,
   output logic                                  almost_full,
   output logic                                  almost_empty,
   output logic [$clog2(DEPTH):0]                count,
`ifdef RING_BUFFER_ERR_FLAG_EN
   output logic                                  overflow_err,
   output logic                                  underflow_err,
`endif
   output logic [$clog2(DEPTH):0]                wptr_check,
   output logic [$clog2(DEPTH):0]                rptr_check
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] set_t;

   set_t          mem_q [DEPTH];
   set_t          dout_q, dout_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] count_q, count_d;
   logic          wr_acc, rd_acc;

   assign full_flag    = (count_q == PW'(DEPTH));
   assign empty_flag   = (count_q == '0);
   assign almost_full  = (count_q >= PW'(AF_LEVEL));
   assign almost_empty = (count_q <= PW'(AE_LEVEL));

   // A full buffer can still take a write when a read frees the slot on the same edge.
   assign wr_acc = wen && (!full_flag || ren);
   assign rd_acc = ren && !empty_flag;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      dout_d  = dout_q;
      if (wr_acc) wptr_d = wptr_q + PW'(1);
      if (rd_acc) begin
         rptr_d = rptr_q + PW'(1);
         dout_d = mem_q[rptr_q[AW-1:0]];
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + PW'(1);
         2'b01:   count_d = count_q - PW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         dout_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         dout_q  <= dout_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_acc) mem_q[wptr_q[AW-1:0]] <= din;
   end

`ifdef RING_BUFFER_ERR_FLAG_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   always_comb begin
      ovf_d = ovf_q | (wen && !wr_acc);
      udf_d = udf_q | (ren && !rd_acc);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign overflow_err  = ovf_q;
   assign underflow_err = udf_q;
`endif

   assign dout       = dout_q;
   assign count      = count_q;
   assign wptr_check = wptr_q;
   assign rptr_check = rptr_q;

endmodule

// File: tb/tb_ring_buffer_param.sv
// Bench for ring_buffer_param at DATA_OF_SET=4, DATA_WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
// Vector table carries hand-derived count/flags; a queue model predicts dout and pointers.
module tb_ring_buffer_param;

   logic             clk = 1'b0;
   logic             rst, wen, ren;
   logic [3:0][7:0]  din, dout;
   logic             full_flag, empty_flag, almost_full, almost_empty;
   logic [2:0]       count, wptr_check, rptr_check;
`ifdef RING_BUFFER_ERR_FLAG_EN
   logic             overflow_err, underflow_err;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ring_buffer_param #(
      .DATA_OF_SET(4), .DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)
   ) dut (
      .clk(clk), .rst(rst), .wen(wen), .ren(ren), .din(din), .dout(dout),
      .full_flag(full_flag), .empty_flag(empty_flag),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
`ifdef RING_BUFFER_ERR_FLAG_EN
      .overflow_err(overflow_err), .underflow_err(underflow_err),
`endif
      .wptr_check(wptr_check), .rptr_check(rptr_check)
   );

   typedef struct {
      logic       r, w, rd;
      logic [7:0] b;
      int         c;
      logic       f, e, af, ae;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] mq[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_dout;
   int          wp, rp;

   function automatic logic [31:0] mk(input logic [7:0] b);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   function automatic vec_t v(input logic r, input logic w, input logic rd, input logic [7:0] b,
                              input int c, input logic f, input logic e, input logic af, input logic ae);
      vec_t x;
      x.r = r; x.w = w; x.rd = rd; x.b = b; x.c = c; x.f = f; x.e = e; x.af = af; x.ae = ae;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input vec_t x, input int idx);
      logic rd_ok, wr_ok;
      rd_ok = 1'b0;
      rst = x.r; wen = x.w; ren = x.rd; din = mk(x.b);
      if (x.r) begin
         mq.delete(); exp_q.delete();
         exp_dout = '0; wp = 0; rp = 0;
      end else begin
         rd_ok = x.rd && (mq.size() > 0);
         wr_ok = x.w && ((mq.size() < 4) || x.rd);
         if (rd_ok) begin
            exp_q.push_back(mq.pop_front());
            rp++;
         end
         if (wr_ok) begin
            mq.push_back(mk(x.b));
            wp++;
         end
      end
      @(posedge clk);
      #1;
      if (rd_ok) exp_dout = exp_q.pop_front();
      chk($sformatf("v%0d.dout", idx), dout, exp_dout);
      chk($sformatf("v%0d.count", idx), 32'(count), 32'(x.c));
      chk($sformatf("v%0d.flags", idx), {28'd0, full_flag, empty_flag, almost_full, almost_empty},
          {28'd0, x.f, x.e, x.af, x.ae});
      chk($sformatf("v%0d.wptr", idx), 32'(wptr_check), 32'(wp % 8));
      chk($sformatf("v%0d.rptr", idx), 32'(rptr_check), 32'(rp % 8));
   endtask

   initial begin
      rst = 1'b1; wen = 1'b0; ren = 1'b0; din = '0;
      exp_dout = '0; wp = 0; rp = 0;

      // r  w  rd  b   cnt  f  e  af ae
      vecs.push_back(v(1, 0, 0,  0,  0, 0, 1, 0, 1));   // reset
      vecs.push_back(v(0, 1, 0,  1,  1, 0, 0, 0, 1));   // fill
      vecs.push_back(v(0, 1, 0,  5,  2, 0, 0, 0, 0));
      vecs.push_back(v(0, 1, 0,  6,  3, 0, 0, 1, 0));
      vecs.push_back(v(0, 1, 0,  7,  4, 1, 0, 1, 0));
      vecs.push_back(v(0, 1, 0,  8,  4, 1, 0, 1, 0));   // write on full rejected
      vecs.push_back(v(0, 0, 1,  0,  3, 0, 0, 1, 0));   // drain 1,5,6,7
      vecs.push_back(v(0, 0, 1,  0,  2, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 1,  0,  1, 0, 0, 0, 1));
      vecs.push_back(v(0, 0, 1,  0,  0, 0, 1, 0, 1));
      vecs.push_back(v(0, 0, 1,  0,  0, 0, 1, 0, 1));   // read on empty ignored
      vecs.push_back(v(1, 0, 0,  0,  0, 0, 1, 0, 1));
      for (int i = 0; i < 6; i++) begin                 // interleaved wrap
         vecs.push_back(v(0, 1, 0, 8'(10 + i), 1, 0, 0, 0, 1));
         vecs.push_back(v(0, 0, 1, 0,          0, 0, 1, 0, 1));
      end
      vecs.push_back(v(0, 1, 0, 20,  1, 0, 0, 0, 1));
      vecs.push_back(v(0, 1, 0, 21,  2, 0, 0, 0, 0));
      vecs.push_back(v(0, 1, 0, 22,  3, 0, 0, 1, 0));
      vecs.push_back(v(0, 1, 0, 23,  4, 1, 0, 1, 0));
      vecs.push_back(v(0, 1, 1,  9,  4, 1, 0, 1, 0));   // full, write+read
      vecs.push_back(v(0, 0, 1,  0,  3, 0, 0, 1, 0));
      vecs.push_back(v(0, 0, 1,  0,  2, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 1,  0,  1, 0, 0, 0, 1));
      vecs.push_back(v(0, 0, 1,  0,  0, 0, 1, 0, 1));   // ends with set 9
      vecs.push_back(v(0, 1, 1,  2,  1, 0, 0, 0, 1));   // empty, write+read: no bypass
      vecs.push_back(v(0, 0, 1,  0,  0, 0, 1, 0, 1));   // gives set 2
      vecs.push_back(v(0, 1, 0, 30,  1, 0, 0, 0, 1));
      vecs.push_back(v(0, 1, 0, 31,  2, 0, 0, 0, 0));
      vecs.push_back(v(1, 1, 1, 32,  0, 0, 1, 0, 1));   // reset beats wen/ren mid-stream
      vecs.push_back(v(0, 0, 1,  0,  0, 0, 1, 0, 1));

      for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

      // Explicit wrap-bit check on the interleaved phase.
      step(v(1, 0, 0, 0, 0, 0, 1, 0, 1), 100);
      for (int i = 0; i < 4; i++) begin
         step(v(0, 1, 0, 8'(40 + i), 1, 0, 0, 0, 1), 101 + 2 * i);
         step(v(0, 0, 1, 0,          0, 0, 1, 0, 1), 102 + 2 * i);
      end
      chk("wrap_msb", 32'(wptr_check[2]), 32'd1);

`ifdef RING_BUFFER_ERR_FLAG_EN
      step(v(1, 0, 0, 0, 0, 0, 1, 0, 1), 200);
      chk("err_reset", {30'd0, overflow_err, underflow_err}, 32'd0);
      for (int i = 0; i < 4; i++) step(v(0, 1, 0, 8'(50 + i), i + 1, i == 3, 0, i >= 2, i == 0), 201 + i);
      chk("ovf_before", 32'(overflow_err), 32'd0);
      step(v(0, 1, 0, 60, 4, 1, 0, 1, 0), 205);
      chk("ovf_set", 32'(overflow_err), 32'd1);
      step(v(0, 0, 1, 0, 3, 0, 0, 1, 0), 206);
      chk("ovf_held", {30'd0, overflow_err, underflow_err}, 32'd2);
      step(v(1, 0, 0, 0, 0, 0, 1, 0, 1), 207);
      chk("err_clear", {30'd0, overflow_err, underflow_err}, 32'd0);
      step(v(0, 0, 1, 0, 0, 0, 1, 0, 1), 208);
      chk("udf_set", {30'd0, overflow_err, underflow_err}, 32'd1);
      step(v(0, 1, 0, 61, 1, 0, 0, 0, 1), 209);
      chk("udf_held", 32'(underflow_err), 32'd1);
      step(v(1, 0, 0, 0, 0, 0, 1, 0, 1), 210);
      chk("udf_clear", 32'(underflow_err), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
